muldiv_sequencer: RTL and testbench

Multi-cycle controller for the HI/LO multiply/divide resource beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decode/control path and runs iterative shift-add multiply or restoring divide over WIDTH cycles. It owns the HI and LO registers and drives an interlock `stall` whenever the pipeline touches HI/LO while an operation is in flight. The `Mul`/`Div`/`WriteHi`/`WriteLo`/`ReadHi`/`ReadLo` controls route into this block instead of the single-cycle ALU.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_sign_fix.sv | 46 ++++
 rtl/muldiv_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared opcode encoding, FSM state type and result constants
//               for the HI/LO multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   // Request opcodes presented on op_i
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   // Quotient reported for a zero divisor; sliced to WIDTH (WIDTH <= 64)
   localparam int unsigned  MAX_WIDTH = 64;
   localparam logic [MAX_WIDTH-1:0] DIVZ_LO = {MAX_WIDTH{1'b1}};

   // MULT and DIV work on magnitudes plus sign flags
   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Combinational sign handling. Entry side turns operands into
//               magnitudes plus sign flags; result side re-applies signs to
//               the product, quotient and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   // entry stage
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               a_neg_o,
   output logic               b_neg_o,
   output logic [WIDTH-1:0]   a_mag_o,
   output logic [WIDTH-1:0]   b_mag_o,
   // result stage
   input  logic               neg_a_i,
   input  logic               neg_b_i,
   input  logic [2*WIDTH-1:0] prod_i,
   input  logic [WIDTH-1:0]   quot_i,
   input  logic [WIDTH-1:0]   rem_i,
   output logic [2*WIDTH-1:0] prod_o,
   output logic [WIDTH-1:0]   quot_o,
   output logic [WIDTH-1:0]   rem_o
);

   assign a_neg_o = signed_i & a_i[WIDTH-1];
   assign b_neg_o = signed_i & b_i[WIDTH-1];

   // The most negative value maps onto itself, which is exactly the unsigned
   // magnitude needed for the shift-add / restoring datapaths.
   assign a_mag_o = a_neg_o ? (-a_i) : a_i;
   assign b_mag_o = b_neg_o ? (-b_i) : b_i;

   // Product and quotient are negative when the operand signs differ;
   // the remainder follows the dividend.
   assign prod_o = (neg_a_i ^ neg_b_i) ? (-prod_i) : prod_i;
   assign quot_o = (neg_a_i ^ neg_b_i) ? (-quot_i) : quot_i;
   assign rem_o  = neg_a_i ? (-rem_i) : rem_i;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle HI/LO multiply/divide controller. Iterative
//               shift-add multiply and restoring divide, one bit per cycle,
//               followed by a sign-fix cycle. Owns HI/LO and drives the
//               pipeline interlock.
// Build macro : MULDIV_FAST_MUL_EN - combinational multiply, MULT/MULTU go
//               straight from IDLE to FIX.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] op1_i,
   input  logic [WIDTH-1:0] op2_i,
   input  logic             read_hi_i,
   input  logic             read_lo_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hilo_out_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;     // {upper, lower} working register
   logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic                 neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic                 is_div_q, is_div_d, divz_q, divz_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic                 done_q, done_d;

   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix, rem_src;
   logic                 last_iter;

   // A zero divisor leaves the dividend magnitude untouched in the low half;
   // re-signing it restores the original op1 for HI.
   assign rem_src = divz_q ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .signed_i (op_is_signed(op_i)),
      .a_i      (op1_i),
      .b_i      (op2_i),
      .a_neg_o  (a_neg),
      .b_neg_o  (b_neg),
      .a_mag_o  (a_mag),
      .b_mag_o  (b_mag),
      .neg_a_i  (neg_a_q),
      .neg_b_i  (neg_b_q),
      .prod_i   (acc_q),
      .quot_i   (acc_q[WIDTH-1:0]),
      .rem_i    (rem_src),
      .prod_o   (prod_fix),
      .quot_o   (quot_fix),
      .rem_o    (rem_fix)
   );

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_step;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring step: shift the next dividend bit into the partial remainder,
   // subtract the divisor if it fits, and shift the quotient bit in at the bottom.
   logic [WIDTH:0]       div_shrem, div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_step;
   assign div_shrem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shrem - {1'b0, opnd_q};
   assign div_ge    = (div_shrem >= {1'b0, opnd_q});
   assign div_step  = {(div_ge ? div_diff[WIDTH-1:0] : div_shrem[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0]   fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

   assign last_iter = (cnt_q == CW'(WIDTH - 1));

   // Next-state, datapath and HI/LO update logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      is_div_d = is_div_q;
      divz_d   = divz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               case (op_i)
                  OP_MULT, OP_MULTU: begin
                     neg_a_d  = a_neg;
                     neg_b_d  = b_neg;
                     opnd_d   = a_mag;
                     is_div_d = 1'b0;
                     divz_d   = 1'b0;
                     cnt_d    = '0;
`ifdef MULDIV_FAST_MUL_EN
                     acc_d    = fast_prod;
                     state_d  = ST_FIX;
`else
                     acc_d    = {{WIDTH{1'b0}}, b_mag};
                     state_d  = ST_MUL;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     neg_a_d  = a_neg;
                     neg_b_d  = b_neg;
                     opnd_d   = b_mag;
                     acc_d    = {{WIDTH{1'b0}}, a_mag};
                     is_div_d = 1'b1;
                     divz_d   = (op2_i == '0);
                     cnt_d    = '0;
                     state_d  = ST_DIV;
                  end
                  OP_MTHI: hi_d = op1_i;
                  OP_MTLO: lo_d = op1_i;
                  default: ;  // reserved opcodes are ignored
               endcase
            end
         end
         ST_MUL: begin
            acc_d = mul_step;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               cnt_d   = '0;
               state_d = ST_FIX;
            end
         end
         ST_DIV: begin
            // Divide by zero keeps counting so the latency is unchanged
            if (!divz_q) begin
               acc_d = div_step;
            end
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               cnt_d   = '0;
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (is_div_q) begin
               lo_d = divz_q ? DIVZ_LO[WIDTH-1:0] : quot_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         is_div_q <= 1'b0;
         divz_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         is_div_q <= is_div_d;
         divz_q   <= divz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign stall_o    = busy_o & (start_i | read_hi_i | read_lo_i);
   assign done_o     = done_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   // HI wins if decode ever raises both reads
   assign hilo_out_o = read_hi_i ? hi_q : (read_lo_i ? lo_q : '0);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed scoreboard bench for muldiv_sequencer. The driver
//               queues the expected HI/LO and latency of each operation; a
//               monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int LAT_MUL = 2;
`else
   localparam int LAT_MUL = W + 2;
`endif
   localparam int LAT_DIV = W + 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  op1 = '0, op2 = '0;
   logic          read_hi = 1'b0, read_lo = 1'b0;
   logic          busy_o, done_o, stall_o;
   logic [W-1:0]  hi_o, lo_o, hilo_out_o;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           lat;
      int           icyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .reset_n_i  (reset_n),
      .start_i    (start),
      .op_i       (op),
      .op1_i      (op1),
      .op2_i      (op2),
      .read_hi_i  (read_hi),
      .read_lo_i  (read_lo),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .stall_o    (stall_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .hilo_out_o (hilo_out_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (reset_n && done_o) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_done: done pulse with nothing outstanding (cycle %0d)", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("hi", 64'(hi_o), 64'(mon_e.hi));
            check("lo", 64'(lo_o), 64'(mon_e.lo));
            check("latency", 64'(cyc - mon_e.icyc), 64'(mon_e.lat));
         end
      end
   end

   // Present a request for one cycle (called just after a rising edge)
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat);
      start = 1'b1; op = o; op1 = a; op2 = b;
      exp_q.push_back('{ehi, elo, lat, cyc});
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait (bounded) until every queued operation has been checked
   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         errors++;
         $display("FAIL drain_timeout: %0d operations never completed", exp_q.size());
         exp_q.delete();
      end
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      bit got;

      // Reset state
      @(negedge clk);
      check("rst_busy",  64'(busy_o),  64'd0);
      check("rst_done",  64'(done_o),  64'd0);
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_hi",    64'(hi_o),    64'd0);
      check("rst_lo",    64'(lo_o),    64'd0);
      check("rst_hilo",  64'(hilo_out_o), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Arithmetic vectors
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT_MUL);
      wait_drain();
      issue(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_MUL);
      wait_drain();
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
      wait_drain();
      issue(OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         LAT_DIV);
      wait_drain();
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, LAT_DIV);
      wait_drain();
      issue(OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, LAT_DIV);
      wait_drain();

      // MFLO and a second request held against a busy divide
      issue(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, LAT_DIV);
      repeat (4) @(posedge clk);
      #1;
      read_lo = 1'b1;
      start = 1'b1; op = OP_DIVU; op1 = 32'd9; op2 = 32'd4;
      bad = 0;
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (done_o) begin
            got = 1'b1;
            check("stall_on_done", 64'(stall_o), 64'd0);
            check("mflo_after_stall", 64'(hilo_out_o), 64'd14);
            exp_q.push_back('{32'd1, 32'd2, LAT_DIV, cyc});
         end else if (!stall_o) begin
            bad++;
         end
      end
      if (!got) begin
         vectors++;
         errors++;
         $display("FAIL stall_timeout: done never seen while stalled");
      end
      check("stall_held", 64'(bad), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      read_lo = 1'b0;
      wait_drain();

      // MTHI / MTLO, read mux
      start = 1'b1; op = OP_MTHI; op1 = 32'hCAFE_BABE;
      @(negedge clk);
      check("mthi_busy", 64'(busy_o), 64'd0);
      @(posedge clk); #1;
      op = OP_MTLO; op1 = 32'h1234_5678;
      @(negedge clk);
      check("mthi_hi", 64'(hi_o), 64'hCAFE_BABE);
      @(posedge clk); #1;
      start = 1'b0;
      read_hi = 1'b1; read_lo = 1'b1;
      @(negedge clk);
      check("mtlo_lo", 64'(lo_o), 64'h1234_5678);
      check("hilo_both_reads", 64'(hilo_out_o), 64'hCAFE_BABE);
      check("mtlo_busy", 64'(busy_o), 64'd0);
      @(posedge clk); #1;
      read_hi = 1'b0;
      @(negedge clk);
      check("hilo_read_lo", 64'(hilo_out_o), 64'h1234_5678);
      @(posedge clk); #1;
      read_lo = 1'b0;

      // Reset in the middle of a multiply discards it
      start = 1'b1; op = OP_MULT; op1 = 32'hFFFF_FFFD; op2 = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("mid_busy", 64'(busy_o), 64'd1);
      check("mid_hi_held", 64'(hi_o), 64'hCAFE_BABE);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy_o), 64'd0);
      check("arst_done", 64'(done_o), 64'd0);
      check("arst_hi",   64'(hi_o),   64'd0);
      check("arst_lo",   64'(lo_o),   64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, LAT_MUL);
      wait_drain();
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
